// File: rtl/riscv_pkg.sv
// Shared types for the memory arbiter: requester owner, arbiter FSM
// states, address/data aliases and the full byte-enable constant.
package riscv_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  be_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } mem_owner_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    localparam be_t BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch (I) and load/store (D).
// Tie policy: MEM_ARB_ROUND_ROBIN_EN alternates, otherwise D always wins.
module mem_arb_pick
    import riscv_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  mem_owner_t i_last_owner,
    output logic       o_pick_valid,
    output mem_owner_t o_pick_owner
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the previous owner.
    logic w_unused_last;
    assign w_unused_last = i_last_owner;
`endif

    // Choose a winner among the pending requesters.
    always_comb begin
        o_pick_valid = i_req_i | i_req_d;
        o_pick_owner = OWN_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req_i && i_req_d) begin
            o_pick_owner = (i_last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (i_req_d) begin
            o_pick_owner = OWN_D;
        end
`else
        if (i_req_d) begin
            o_pick_owner = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D), one
// outstanding access, response timeout. Option: MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  addr_t       i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output data_t       i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  addr_t       d_addr,
    input  data_t       d_wdata,
    input  be_t         d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output data_t       d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output addr_t       m_addr,
    output data_t       m_wdata,
    output be_t         m_be,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  data_t       m_rdata,
    output logic        busy
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    mem_owner_t       r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_m_req;
    logic             r_m_we;
    addr_t            r_m_addr;
    data_t            r_m_wdata;
    be_t              r_m_be;
    logic             w_pick_valid;
    mem_owner_t       w_pick_owner;
    logic             w_latch;
    logic             w_gnt;
    logic             w_rsp;
    logic             w_err;

    mem_arb_pick u_pick (
        .i_req_i      (i_req),
        .i_req_d      (d_req),
        .i_last_owner (r_owner),
        .o_pick_valid (w_pick_valid),
        .o_pick_owner (w_pick_owner)
    );

    // State, timeout counter and memory request flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
            r_m_req <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_m_req <= (w_state_nxt == ARB_ISSUE);
        end
    end

    // Next state, handshake strobes and timeout detection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_latch     = 1'b0;
        w_gnt       = 1'b0;
        w_rsp       = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_gnt) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (m_rvalid) begin
                    w_rsp       = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
                    w_rsp       = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Capture the winner's request fields when leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= OWN_I;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_be    <= '0;
        end else if (w_latch) begin
            r_owner <= w_pick_owner;
            if (w_pick_owner == OWN_D) begin
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
                r_m_be    <= d_be;
            end else begin
                r_m_we    <= 1'b0;
                r_m_addr  <= i_addr;
                r_m_wdata <= '0;
                r_m_be    <= BE_ALL;
            end
        end
    end

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_be    = r_m_be;
    assign busy    = (r_state != ARB_IDLE);

    assign i_gnt    = w_gnt & (r_owner == OWN_I);
    assign d_gnt    = w_gnt & (r_owner == OWN_D);
    assign i_rvalid = w_rsp & (r_owner == OWN_I);
    assign d_rvalid = w_rsp & (r_owner == OWN_D);
    assign i_err    = w_err & (r_owner == OWN_I);
    assign d_err    = w_err & (r_owner == OWN_D);
    assign i_rdata  = (i_rvalid && !w_err) ? m_rdata : '0;
    assign d_rdata  = (d_rvalid && !w_err) ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random I/D requesters against a
// behavioural memory, plus directed latency, timeout and reset cases.
module tb_mem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        m_req, m_we, m_gnt, m_rvalid, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_i[$];
    rsp_t exp_d[$];
    int   checks = 0;
    int   failures = 0;
    logic lst_i = 1'b0;
    logic lst_d = 1'b0;
    bit   i_done = 1'b0;
    bit   d_done = 1'b0;
    bit   last_d = 1'b0;

    mem_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_be(m_be), .m_gnt(m_gnt),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return (a ^ 32'h5A5A_5A5A) + 32'h1357_9BDF;
    endfunction

    // Addresses with bit 31 set are never answered by the memory model.
    function automatic rsp_t exp_rsp(input logic [31:0] a);
        rsp_t r;
        r.err  = a[31];
        r.data = a[31] ? 32'h0 : hsh(a);
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a     = $urandom;
        a[31] = ($urandom_range(0, 7) == 0);
        return a;
    endfunction

    function automatic logic [140:0] all_outs();
        return {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid,
                d_rdata, d_err, m_req, m_we, m_addr, m_wdata, m_be, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected responses whenever a requester sees rvalid.
    always @(negedge clk) begin : mon
        rsp_t e;
        lst_i = i_req;
        lst_d = d_req;
        if (i_rvalid) begin
            if (exp_i.size() == 0) begin
                checks++; failures++;
                $display("FAIL i_unexpected_rvalid actual=1 required=0");
            end else begin
                e = exp_i.pop_front();
                chk("i_rsp", {i_err, i_rdata}, {e.err, e.data});
            end
        end else begin
            chk("i_idle_zero", {i_err, i_rdata}, 0);
        end
        if (d_rvalid) begin
            if (exp_d.size() == 0) begin
                checks++; failures++;
                $display("FAIL d_unexpected_rvalid actual=1 required=0");
            end else begin
                e = exp_d.pop_front();
                chk("d_rsp", {d_err, d_rdata}, {e.err, e.data});
            end
        end else begin
            chk("d_idle_zero", {d_err, d_rdata}, 0);
        end
        chk("gnt_excl", i_gnt & d_gnt, 0);
    end

    task automatic run_i(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            i_addr = rand_addr();
            i_req  = 1'b1;
            exp_i.push_back(exp_rsp(i_addr));
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!i_gnt && w < 300);
            if (!i_gnt) chk("i_gnt_timeout", 0, 1);
            step();
            i_req = 1'b0;
        end
        i_done = 1'b1;
    endtask

    task automatic run_d(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            d_addr  = rand_addr();
            d_we    = $urandom_range(0, 1);
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
            d_req   = 1'b1;
            exp_d.push_back(exp_rsp(d_addr));
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!d_gnt && w < 300);
            if (!d_gnt) chk("d_gnt_timeout", 0, 1);
            step();
            d_req = 1'b0;
        end
        d_done = 1'b1;
    endtask

    // Memory model: random grant and response delays; checks that the
    // issued request belongs to the requester the arbitration rule picks.
    task automatic mem_model();
        int          st = 0;
        int          dly = 0;
        int          guard = 0;
        bit          wd = 1'b0;
        logic [31:0] a = '0;
        while (!(i_done && d_done && st == 0 &&
                 exp_i.size() == 0 && exp_d.size() == 0)) begin
            step();
            guard++;
            if (guard > 20000) begin
                chk("mem_model_timeout", guard, 0);
                break;
            end
            m_gnt = 1'b0;
            m_rvalid = 1'b0;
            m_rdata = '0;
            if (st == 0 && m_req) begin
                if (!lst_i && !lst_d) chk("spurious_m_req", 1, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                wd = lst_d && (!lst_i || !last_d);
`else
                wd = lst_d;
`endif
                last_d = wd;
                if (wd) begin
                    chk("m_fields_d", {m_we, m_be, m_addr, m_wdata},
                        {d_we, d_be, d_addr, d_wdata});
                end else begin
                    chk("m_fields_i", {m_we, m_be, m_addr},
                        {1'b0, 4'hF, i_addr});
                end
                dly = $urandom_range(0, 2);
                st = 1;
            end
            if (st == 1) begin
                if (dly == 0) begin
                    m_gnt = 1'b1;
                    #1;
                    chk("gnt_owner", {i_gnt, d_gnt}, wd ? 2'b01 : 2'b10);
                    a  = m_addr;
                    st = a[31] ? 0 : 2;
                    dly = $urandom_range(0, 5);
                end else begin
                    dly--;
                end
            end else if (st == 2) begin
                if (dly == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = hsh(a);
                    st = 0;
                end else begin
                    dly--;
                end
            end
        end
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
    endtask

    task automatic wait_m_req(input string name);
        int w = 0;
        while (!m_req && w < 10) begin
            step();
            w++;
        end
        chk(name, m_req, 1);
    endtask

    initial begin
        int n;
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
        repeat (2) step();
        chk("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        step();

        // Fetch with 2-cycle grant and 3-cycle response delay.
        i_addr = 32'h100;
        i_req  = 1'b1;
        step();
        chk("t1_issue", {m_req, m_we, m_be, m_addr, busy},
            {1'b1, 1'b0, 4'hF, 32'h100, 1'b1});
        step();
        chk("t1_no_early_gnt", i_gnt, 0);
        step();
        m_gnt = 1'b1;
        #1;
        chk("t1_gnt", {i_gnt, d_gnt}, 2'b10);
        exp_i.push_back('{1'b0, 32'hDEAD_BEEF});
        step();
        m_gnt = 1'b0;
        i_req = 1'b0;
        chk("t1_m_req_drop", m_req, 0);
        repeat (2) step();
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("t1_rsp", {i_rvalid, i_err, i_rdata}, {2'b10, 32'hDEAD_BEEF});
        step();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        chk("t1_idle", busy, 0);

        fork
            run_i(60);
            run_d(60);
            mem_model();
        join

        // Load that never gets a response times out on WAIT cycle TMO.
        step();
        d_addr = 32'h40; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
        exp_d.push_back('{1'b1, 32'h0});
        wait_m_req("t4_m_req");
        m_gnt = 1'b1;
        #1;
        chk("t4_gnt", {i_gnt, d_gnt}, 2'b01);
        step();
        m_gnt = 1'b0;
        d_req = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            if (d_rvalid || n >= 20) break;
            step();
            n++;
        end
        chk("t4_timeout_cycle", n, TMO);
        step();
        chk("t4_busy_drop", busy, 0);
        repeat (2) step();
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_F00D;
        #1;
        chk("t4_late_dropped", {i_rvalid, d_rvalid}, 0);
        step();
        m_rvalid = 1'b0;
        m_rdata  = '0;

        // Reset during WAIT aborts with no response.
        d_addr = 32'h44; d_req = 1'b1;
        wait_m_req("t6_m_req");
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        d_req = 1'b0;
        step();
        chk("t6_in_wait", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs", all_outs(), 0);
        step();
        rst = 1'b0;
        step();
        m_rvalid = 1'b1;
        m_rdata  = 32'h1111_2222;
        #1;
        chk("t6_post_reset_drop", {i_rvalid, d_rvalid, busy}, 0);
        step();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        repeat (12) step();
        chk("t6_idle", busy, 0);

        chk("exp_i_drained", exp_i.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
